router_fsm: RTL and testbench

- Packet-sequencing controller for the 1x3 router. It decodes the 2-bit destination address carried in the header byte and steers the synchronizer and the register block through the header, payload, full-stall and parity phases.
- It tracks the destination FIFO's empty and soft-reset status and asserts busy toward the source whenever new input must be held off.
- It has no datapath of its own: it outputs state-decoded control strobes only.

---
 rtl/router_fsm.sv | 124 ++++++++++++
 tb/tb_router_fsm.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: decodes the header address
// and drives Moore control strobes for the synchronizer and the register block.
module router_fsm #(
  parameter int unsigned             ADDR_W       = 2,
  parameter logic [ADDR_W-1:0]       INVALID_ADDR = '1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              full_state,
  output logic              laf_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;

  logic hdr_empty;   // empty flag of the port addressed by the incoming header
  logic dest_empty;  // empty flag of the latched destination
  logic dest_srst;   // soft reset of the latched destination

  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      ADDR_W'(0): hdr_empty = fifo_empty_0;
      ADDR_W'(1): hdr_empty = fifo_empty_1;
      ADDR_W'(2): hdr_empty = fifo_empty_2;
      default:    hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    dest_empty = 1'b0;
    dest_srst  = 1'b0;
    case (dest_addr_q)
      ADDR_W'(0): begin dest_empty = fifo_empty_0; dest_srst = soft_reset_0; end
      ADDR_W'(1): begin dest_empty = fifo_empty_1; dest_srst = soft_reset_1; end
      ADDR_W'(2): begin dest_empty = fifo_empty_2; dest_srst = soft_reset_2; end
      default:    begin dest_empty = 1'b0;         dest_srst = 1'b0;         end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dest_addr_d = dest_addr_q;
    if (state_q != DECODE_ADDRESS && dest_srst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && data_in != INVALID_ADDR) begin
            dest_addr_d = data_in;
            state_d     = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: if (dest_empty) state_d = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          // Full takes precedence so a stalled final byte is not lost.
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: if (!fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DECODE_ADDRESS;
      dest_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      dest_addr_q <= dest_addr_d;
    end
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == LOAD_AFTER_FULL);
  assign busy          = (state_q == LOAD_FIRST_DATA) || (state_q == LOAD_PARITY) ||
                         (state_q == FIFO_FULL_STATE) || (state_q == LOAD_AFTER_FULL) ||
                         (state_q == WAIT_TILL_EMPTY) || (state_q == CHECK_PARITY_ERROR);

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: checks the full Moore output vector after each edge.
module tb_router_fsm;

  logic       clock, reset, pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state;
  logic       write_enb_reg, rst_int_reg, busy;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned wen_cnt, rst_cnt;

  // {detect_add, lfd, ld, full, laf, write_enb_reg, rst_int_reg, busy}
  localparam logic [7:0] O_DEC  = 8'b1000_0000;
  localparam logic [7:0] O_LFD  = 8'b0100_0001;
  localparam logic [7:0] O_LD   = 8'b0010_0100;
  localparam logic [7:0] O_LP   = 8'b0000_0101;
  localparam logic [7:0] O_FULL = 8'b0001_0001;
  localparam logic [7:0] O_LAF  = 8'b0000_1101;
  localparam logic [7:0] O_WAIT = 8'b0000_0001;
  localparam logic [7:0] O_CPE  = 8'b0000_0011;

  logic [7:0] obs;
  assign obs = {detect_add, lfd_state, ld_state, full_state, laf_state,
                write_enb_reg, rst_int_reg, busy};

  router_fsm #(.ADDR_W(2), .INVALID_ADDR(2'b11)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    if (write_enb_reg) wen_cnt++;
    if (rst_int_reg)   rst_cnt++;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    wen_cnt = 0; rst_cnt = 0;

    // Reset for two cycles, then idle
    step(); step();            chk("reset", O_DEC);
    reset = 1'b0;  step();     chk("idle_after_reset", O_DEC);

    // Packet to port 1: header, 4 payload cycles, parity
    data_in = 2'b01; pkt_valid = 1'b1; fifo_empty_1 = 1'b1;
    wen_cnt = 0; rst_cnt = 0;
    step();                    chk("p1_lfd", O_LFD);
    step();                    chk("p1_ld1", O_LD);
    step();                    chk("p1_ld2", O_LD);
    step();                    chk("p1_ld3", O_LD);
    step();                    chk("p1_ld4", O_LD);
    pkt_valid = 1'b0;
    step();                    chk("p1_lp", O_LP);
    step();                    chk("p1_cpe", O_CPE);
    step();                    chk("p1_dec", O_DEC);
    chk_cnt("p1_wen_cycles", wen_cnt, 5);
    chk_cnt("p1_rst_int_cycles", rst_cnt, 1);
    fifo_empty_1 = 1'b0;

    // Port 2 not empty for 3 cycles
    data_in = 2'b10; pkt_valid = 1'b1; fifo_empty_2 = 1'b0;
    step();                    chk("p2_wait1", O_WAIT);
    step();                    chk("p2_wait2", O_WAIT);
    step();                    chk("p2_wait3", O_WAIT);
    fifo_empty_2 = 1'b1;
    step();                    chk("p2_lfd", O_LFD);
    step();                    chk("p2_ld", O_LD);

    // Full and pkt_valid low together: full wins
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step();                    chk("p2_full1", O_FULL);
    step();                    chk("p2_full2", O_FULL);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    step();                    chk("p2_laf", O_LAF);
    step();                    chk("p2_lp", O_LP);
    low_pkt_valid = 1'b0;
    step();                    chk("p2_cpe", O_CPE);
    step();                    chk("p2_dec", O_DEC);

    // Invalid address is never accepted
    data_in = 2'b11; pkt_valid = 1'b1;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    step();                    chk("inv_dec1", O_DEC);
    step();                    chk("inv_dec2", O_DEC);

    // Soft reset: only the selected port matters
    data_in = 2'b00;
    step();                    chk("sr_lfd", O_LFD);
    step();                    chk("sr_ld", O_LD);
    soft_reset_1 = 1'b1;
    step();                    chk("sr_other_ignored", O_LD);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    step();                    chk("sr_selected", O_DEC);
    soft_reset_0 = 1'b0; pkt_valid = 1'b0;
    step();                    chk("sr_idle", O_DEC);

    // LOAD_AFTER_FULL resuming to LOAD_DATA, then parity_done exit
    pkt_valid = 1'b1;
    step();                    chk("laf_lfd", O_LFD);
    step();                    chk("laf_ld", O_LD);
    fifo_full = 1'b1;
    step();                    chk("laf_full", O_FULL);
    fifo_full = 1'b0;
    step();                    chk("laf_laf1", O_LAF);
    step();                    chk("laf_resume_ld", O_LD);
    fifo_full = 1'b1;
    step();                    chk("laf_full2", O_FULL);
    fifo_full = 1'b0; parity_done = 1'b1;
    step();                    chk("laf_laf2", O_LAF);
    step();                    chk("laf_parity_done", O_DEC);
    parity_done = 1'b0; pkt_valid = 1'b0;

    // CHECK_PARITY_ERROR with fifo_full goes to FIFO_FULL_STATE
    pkt_valid = 1'b1;
    step();                    chk("cpe_lfd", O_LFD);
    step();                    chk("cpe_ld", O_LD);
    pkt_valid = 1'b0;
    step();                    chk("cpe_lp", O_LP);
    fifo_full = 1'b1;
    step();                    chk("cpe_cpe", O_CPE);
    step();                    chk("cpe_to_full", O_FULL);

    // Reset while stalled full, inputs still active
    reset = 1'b1; pkt_valid = 1'b1;
    step();                    chk("rst_mid_pkt", O_DEC);
    reset = 1'b0; pkt_valid = 1'b0; fifo_full = 1'b0;
    step();                    chk("rst_idle", O_DEC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
